// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared constants and types for the Lab7 branch datapath.
//   XLEN        : PC / immediate width
//   INSTR_BYTES : bytes per instruction (sequential PC increment)
//   state_e     : fetch FSM encoding used by branch_pc_unit
//   CBZ_OPCODE  : 8-bit CBZ opcode, kept here for the decode stage
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [7:0] CBZ_OPCODE = 8'b10110100;

endpackage : branch_pkg

// File: rtl/branch_target_adder.sv
// ---------------------------------------------------------------------------
// branch_target_adder
// Combinational PC-relative branch target: i_br_pc + (i_se_imm << 2).
// The immediate is a word offset; the shift discards its top two bits and
// the sum wraps modulo 2^XLEN, so negative offsets work as two's complement.
// Ports:
//   i_br_pc    in  XLEN  PC of the branch instruction
//   i_se_imm   in  XLEN  sign-extended word offset
//   o_target   out XLEN  byte address of the branch target
// ---------------------------------------------------------------------------
module branch_target_adder
    import branch_pkg::*;
#(
    parameter int XLEN = branch_pkg::XLEN
) (
    input  logic [XLEN-1:0] i_br_pc,
    input  logic [XLEN-1:0] i_se_imm,
    output logic [XLEN-1:0] o_target
);

    assign o_target = i_br_pc + (i_se_imm << 2);

endmodule : branch_target_adder

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// Program counter and fetch-slot control for the Lab7 branch datapath.
// Advances the PC by 4 each cycle; on a taken CBZ redirects the PC to the
// branch target and inserts FLUSH_CYCLES bubble cycles (if_valid low).
// Ports:
//   clk          in   1     rising-edge clock
//   reset        in   1     asynchronous active-high reset
//   stall        in   1     hold PC and fetch state this cycle
//   br_valid     in   1     branch-resolve inputs valid this cycle
//   branch       in   1     decoded CBZ
//   zero         in   1     ALU zero flag of the CBZ operand
//   se_imm       in   XLEN  sign-extended word offset
//   br_pc        in   XLEN  PC of the branch being resolved
//   pc           out  XLEN  current fetch PC
//   if_valid     out  1     current fetch slot valid
//   taken        out  1     pulse: redirect happened at the last edge
//   taken_count  out  CNT_W saturating count of taken branches
//   dbg_state    out  2     FSM state (BOOT/RUN/FLUSH) for debug
//
// Interface semantics: br_valid qualifies branch, zero, se_imm and br_pc as a
// group in the cycle it is high; there is no ready, the unit always accepts.
// When br_valid is low those four inputs are ignored. A redirect takes
// priority over stall, which takes priority over the normal advance.
// ---------------------------------------------------------------------------
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int              XLEN         = branch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 1,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             branch,
    input  logic             zero,
    input  logic [XLEN-1:0]  se_imm,
    input  logic [XLEN-1:0]  br_pc,
    output logic [XLEN-1:0]  pc,
    output logic             if_valid,
    output logic             taken,
    output logic [CNT_W-1:0] taken_count,
    output logic [1:0]       dbg_state
);

    // FLUSH_CYCLES is at most 7, so the remaining-bubble counter fits in 3 bits.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              r_if_valid;
    logic              w_if_valid_nxt;
    logic              r_taken;
    logic              w_taken_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_fcnt;
    logic [2:0]        w_fcnt_nxt;
    logic [XLEN-1:0]   w_target;
    logic              w_take;

    branch_target_adder #(
        .XLEN(XLEN)
    ) u_target (
        .i_br_pc  (br_pc),
        .i_se_imm (se_imm),
        .o_target (w_target)
    );

    assign w_take = br_valid & branch & zero;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_taken_nxt    = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_fcnt_nxt     = r_fcnt;
        case (r_state)
            // One idle edge after reset so RESET_PC itself is fetched first.
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_if_valid_nxt = 1'b1;
            end
            ST_RUN, ST_FLUSH: begin
                if (w_take) begin
                    w_pc_nxt       = w_target;
                    w_if_valid_nxt = 1'b0;
                    w_taken_nxt    = 1'b1;
                    w_fcnt_nxt     = FLUSH_LOAD;
                    w_state_nxt    = ST_FLUSH;
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (!stall) begin
                    if (r_state == ST_RUN) begin
                        w_pc_nxt       = r_pc + XLEN'(INSTR_BYTES);
                        w_if_valid_nxt = 1'b1;
                    end else if (r_fcnt == 3'd0) begin
                        // PC already holds the target; it is fetched now.
                        w_state_nxt    = ST_RUN;
                        w_if_valid_nxt = 1'b1;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_taken    <= 1'b0;
            r_cnt      <= '0;
            r_fcnt     <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_taken    <= w_taken_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fcnt     <= w_fcnt_nxt;
        end
    end

    assign pc          = r_pc;
    assign if_valid    = r_if_valid;
    assign taken       = r_taken;
    assign taken_count = r_cnt;
    assign dbg_state   = r_state;

endmodule : branch_pc_unit

// File: tb/tb_branch_pc_unit.sv
// Two instances share stimulus: u_dut0 uses defaults (FLUSH_CYCLES=1,
// CNT_W=16); u_dut1 uses FLUSH_CYCLES=3, CNT_W=4.
module tb_branch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic        branch;
    logic        zero;
    logic [63:0] se_imm;
    logic [63:0] br_pc;

    logic [63:0] pc0, pc1;
    logic        ifv0, ifv1, tk0, tk1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [1:0]  st0, st1;

    int n_cmp;
    int n_err;

    // Reference model state, index 0 -> u_dut0, 1 -> u_dut1.
    logic [63:0] m_pc  [2];
    logic        m_ifv [2];
    logic        m_tk  [2];
    logic [15:0] m_cnt [2];
    int          m_st  [2];
    int          m_fc  [2];

    logic [155:0] exp_q[$];

    branch_pc_unit u_dut0 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .branch(branch), .zero(zero), .se_imm(se_imm), .br_pc(br_pc),
        .pc(pc0), .if_valid(ifv0), .taken(tk0), .taken_count(cnt0),
        .dbg_state(st0)
    );

    branch_pc_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .branch(branch), .zero(zero), .se_imm(se_imm), .br_pc(br_pc),
        .pc(pc1), .if_valid(ifv1), .taken(tk1), .taken_count(cnt1),
        .dbg_state(st1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    function automatic logic [155:0] pack_model();
        return {m_pc[0], m_ifv[0], m_tk[0], m_cnt[0], 2'(m_st[0]),
                m_pc[1], m_ifv[1], m_tk[1], m_cnt[1][3:0], 2'(m_st[1])};
    endfunction

    always @(posedge clk) begin
        logic [155:0] e;
        logic [155:0] a;
        #2;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc0, ifv0, tk0, cnt0, st0, pc1, ifv1, tk1, cnt1, st1};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got %h exp %h", $time, a, e);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 64'h0; m_ifv[i] = 1'b0; m_tk[i] = 1'b0;
            m_cnt[i] = 16'h0; m_st[i] = 0; m_fc[i] = 0;
        end
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive inputs, predict the next rising edge,
    // then return at the following falling edge.
    task automatic tick(input logic bv, input logic br, input logic z,
                        input logic st, input logic [63:0] bpc,
                        input logic [63:0] imm);
        logic        tk;
        logic [63:0] tgt;
        int          fl;
        logic [15:0] cmax;
        stall = st; br_valid = bv; branch = br; zero = z;
        br_pc = bpc; se_imm = imm;
        tk  = bv & br & z;
        tgt = bpc + imm * 64'd4;
        for (int i = 0; i < 2; i++) begin
            fl   = (i == 0) ? 1 : 3;
            cmax = (i == 0) ? 16'hFFFF : 16'h000F;
            m_tk[i] = 1'b0;
            if (m_st[i] == 0) begin
                m_st[i] = 1; m_ifv[i] = 1'b1;
            end else if (tk) begin
                m_pc[i] = tgt; m_ifv[i] = 1'b0; m_tk[i] = 1'b1;
                m_fc[i] = fl - 1; m_st[i] = 2;
                if (m_cnt[i] != cmax) m_cnt[i] = m_cnt[i] + 16'd1;
            end else if (!st) begin
                if (m_st[i] == 1) begin
                    m_pc[i] = m_pc[i] + 64'd4; m_ifv[i] = 1'b1;
                end else if (m_fc[i] == 0) begin
                    m_st[i] = 1; m_ifv[i] = 1'b1;
                end else begin
                    m_fc[i] = m_fc[i] - 1;
                end
            end
        end
        exp_q.push_back(pack_model());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (pc0 !== 64'h0 || pc1 !== 64'h0) begin n_err++; $display("FAIL reset_pc got %h/%h exp 0", pc0, pc1); end
        n_cmp++; if (ifv0 !== 1'b0 || ifv1 !== 1'b0) begin n_err++; $display("FAIL reset_ifv got %b/%b exp 0", ifv0, ifv1); end
        n_cmp++; if (tk0 !== 1'b0 || cnt0 !== 16'h0 || cnt1 !== 4'h0) begin n_err++; $display("FAIL reset_cnt got %b %h %h exp 0", tk0, cnt0, cnt1); end
        reset = 1'b0;
        idle(1);
        n_cmp++; if (ifv0 !== 1'b1 || pc0 !== 64'h0) begin n_err++; $display("FAIL boot_edge1 got ifv=%b pc=%h exp ifv=1 pc=0", ifv0, pc0); end
        idle(1);
        n_cmp++; if (pc0 !== 64'h4) begin n_err++; $display("FAIL boot_edge2 got %h exp 4", pc0); end
        idle(1);
        n_cmp++; if (pc0 !== 64'h8 || pc1 !== 64'h8) begin n_err++; $display("FAIL boot_edge3 got %h/%h exp 8", pc0, pc1); end
    endtask

    task automatic test_cbz_taken();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFD);
        n_cmp++; if (pc0 !== 64'h34 || tk0 !== 1'b1 || ifv0 !== 1'b0) begin n_err++; $display("FAIL cbz_redirect got pc=%h tk=%b ifv=%b exp 34 1 0", pc0, tk0, ifv0); end
        idle(1);
        n_cmp++; if (pc0 !== 64'h34 || ifv0 !== 1'b1 || cnt0 !== 16'd1) begin n_err++; $display("FAIL cbz_refetch got pc=%h ifv=%b cnt=%0d exp 34 1 1", pc0, ifv0, cnt0); end
        n_cmp++; if (ifv1 !== 1'b0) begin n_err++; $display("FAIL cbz_f3_bubble got %b exp 0", ifv1); end
        idle(2);
        n_cmp++; if (ifv1 !== 1'b1 || pc1 !== 64'h34) begin n_err++; $display("FAIL cbz_f3_refetch got ifv=%b pc=%h exp 1 34", ifv1, pc1); end
    endtask

    task automatic test_cbz_not_taken();
        logic [63:0] prev;
        prev = m_pc[0];
        tick(1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFD);
        n_cmp++; if (pc0 !== prev + 64'd4 || tk0 !== 1'b0 || cnt0 !== 16'd1) begin n_err++; $display("FAIL cbz_not_taken got pc=%h tk=%b cnt=%0d exp %h 0 1", pc0, tk0, cnt0, prev + 64'd4); end
    endtask

    task automatic test_stall_redirect();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h8, 64'h2);
        n_cmp++; if (pc0 !== 64'h10 || pc1 !== 64'h10) begin n_err++; $display("FAIL stall_setup got %h/%h exp 10", pc0, pc1); end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
            n_cmp++; if (pc0 !== 64'h10 || tk0 !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d got pc=%h tk=%b exp 10 0", k, pc0, tk0); end
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1, 64'h10, 64'h5);
        n_cmp++; if (pc0 !== 64'h24 || tk0 !== 1'b1) begin n_err++; $display("FAIL stall_take got pc=%h tk=%b exp 24 1", pc0, tk0); end
        idle(4);
    endtask

    task automatic test_flush_redirect();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h10);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h100, 64'h2);
        n_cmp++; if (pc1 !== 64'h108 || ifv1 !== 1'b0 || tk1 !== 1'b1) begin n_err++; $display("FAIL flush_retake got pc=%h ifv=%b tk=%b exp 108 0 1", pc1, ifv1, tk1); end
        for (int k = 0; k < 2; k++) begin
            idle(1);
            n_cmp++; if (ifv1 !== 1'b0) begin n_err++; $display("FAIL flush_bubble%0d got %b exp 0", k, ifv1); end
        end
        idle(1);
        n_cmp++; if (ifv1 !== 1'b1 || pc1 !== 64'h108) begin n_err++; $display("FAIL flush_end got ifv=%b pc=%h exp 1 108", ifv1, pc1); end
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1);
        n_cmp++; if (pc0 !== 64'h0 || pc1 !== 64'h0) begin n_err++; $display("FAIL wrap got %h/%h exp 0", pc0, pc1); end
        idle(4);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++)
            tick(1'b1, 1'b1, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        n_cmp++; if (cnt1 !== 4'hF) begin n_err++; $display("FAIL sat_cnt4 got %h exp f", cnt1); end
        n_cmp++; if (cnt0 !== 16'd26) begin n_err++; $display("FAIL cnt16 got %0d exp 26", cnt0); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                 {$urandom, $urandom}, {$urandom, $urandom});
        idle(4);
    endtask

    task automatic test_reset_mid_flush();
        tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h200, 64'h0);
        reset = 1'b1;
        #1;
        n_cmp++; if (pc0 !== 64'h0 || pc1 !== 64'h0 || ifv1 !== 1'b0 || tk0 !== 1'b0 || tk1 !== 1'b0) begin n_err++; $display("FAIL async_reset got pc=%h/%h ifv=%b tk=%b/%b exp 0", pc0, pc1, ifv1, tk0, tk1); end
        n_cmp++; if (cnt0 !== 16'h0 || cnt1 !== 4'h0 || st0 !== 2'd0 || st1 !== 2'd0) begin n_err++; $display("FAIL async_reset_cnt got %h/%h st=%0d/%0d exp 0", cnt0, cnt1, st0, st1); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        n_cmp++; if (pc0 !== 64'h8 || ifv0 !== 1'b1) begin n_err++; $display("FAIL post_reset got pc=%h ifv=%b exp 8 1", pc0, ifv0); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; branch = 1'b0;
        zero = 1'b0; se_imm = 64'h0; br_pc = 64'h0;
        @(negedge clk);
        test_reset();
        test_cbz_taken();
        test_cbz_not_taken();
        test_stall_redirect();
        test_flush_redirect();
        test_wrap();
        test_saturation();
        test_back_to_back();
        test_reset_mid_flush();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_branch_pc_unit
